// File: rtl/mac_ctrl_fsm.sv
// Control FSM for the quadratic-equation MAC datapath: job sequencing, latency tracking and handshake.
// Optional MAC_ERR_CHECK_EN adds a sticky protocol/illegal-mode error flag; otherwise err is tied low.
//
// state    | meaning
// ST_IDLE  | waiting for the first legal sample of a job
// ST_RUN   | job active, accepting samples until last_in
// ST_FLUSH | last sample accepted, draining PIPE_LAT cycles of datapath latency
module mac_ctrl_fsm #(
   parameter int NUM_MODES = 4,
   parameter int MODE_W    = 2,
   parameter int PIPE_LAT  = 2,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [MODE_W-1:0]    mode,
   input  logic                 valid_in,
   input  logic                 last_in,
   output logic                 ready,
   output logic [NUM_MODES-1:0] enable_mode,
   output logic [MODE_W-1:0]    result_sel,
   output logic                 valid_out,
   output logic                 done,
   output logic [CNT_W-1:0]     sample_count,
   output logic                 err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam int FL_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   logic [1:0]          state;
   logic [1:0]          next_state;
   logic [PIPE_LAT-1:0] acc_pipe;
   logic [FL_W-1:0]     flush_cnt;
   logic                stream;
   logic                mode_legal;
   logic                accept;
   logic                start;
   logic                finish;

   assign mode_legal = int'(mode) < NUM_MODES;
   assign accept     = valid_in && ready && ((state != ST_IDLE) || mode_legal);
   assign start      = accept && (state == ST_IDLE);
   assign finish     = (state == ST_FLUSH) && (flush_cnt == '0);

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = last_in ? ST_FLUSH : ST_RUN;
         ST_RUN:   if (accept && last_in) next_state = ST_FLUSH;
         ST_FLUSH: if (finish) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         ready        <= 1'b1;
         enable_mode  <= '0;
         result_sel   <= '0;
         valid_out    <= 1'b0;
         done         <= 1'b0;
         sample_count <= '0;
         acc_pipe     <= '0;
         flush_cnt    <= '0;
         stream       <= 1'b0;
      end else begin
         state <= next_state;
         ready <= (next_state != ST_FLUSH);

         // terminal count of this down-counter marks the final strobe edge
         if (accept && last_in)
            flush_cnt <= FL_W'(PIPE_LAT - 1);
         else if ((state == ST_FLUSH) && (flush_cnt != '0))
            flush_cnt <= flush_cnt - 1'b1;

         if (start) begin
            result_sel   <= mode;
            sample_count <= CNT_W'(1);
            enable_mode  <= NUM_MODES'(1) << mode;
            stream       <= (mode == '0);
         end else begin
            if (accept && (sample_count != '1))
               sample_count <= sample_count + 1'b1;
            if (finish)
               enable_mode <= '0;
         end

         acc_pipe[0] <= accept;
         for (int i = 1; i < PIPE_LAT; i++)
            acc_pipe[i] <= acc_pipe[i-1];

         // in streaming mode the final sample's pipe strobe lands on the same edge as finish
         valid_out <= stream ? acc_pipe[PIPE_LAT-1] : finish;
         done      <= finish;
      end
   end

`ifdef MAC_ERR_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err <= 1'b0;
      else if (start)
         err <= 1'b0;
      else if (valid_in && (((state == ST_IDLE) && !mode_legal) || (state == ST_FLUSH)))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_ctrl_fsm.sv
// Bench for mac_ctrl_fsm: directed job sequences then random traffic, checked every cycle
// against an event-based model of accepted samples and their strobe times.
module tb_mac_ctrl_fsm;

   localparam int NM = 3;
   localparam int MW = 2;
   localparam int PL = 2;
   localparam int CW = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [MW-1:0]  mode = '0;
   logic           valid_in = 1'b0;
   logic           last_in = 1'b0;
   logic           ready;
   logic [NM-1:0]  enable_mode;
   logic [MW-1:0]  result_sel;
   logic           valid_out;
   logic           done;
   logic [CW-1:0]  sample_count;
   logic           err;

   mac_ctrl_fsm #(.NUM_MODES(NM), .MODE_W(MW), .PIPE_LAT(PL), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .mode(mode), .valid_in(valid_in), .last_in(last_in),
      .ready(ready), .enable_mode(enable_mode), .result_sel(result_sel),
      .valid_out(valid_out), .done(done), .sample_count(sample_count), .err(err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // model: phase 0 idle, 1 running, 2 flushing until edge end_e
   int ph = 0;
   int end_e = 0;
   int m_sel = 0;
   int m_cnt = 0;
   int m_en = 0;
   bit m_stream = 0;
   bit m_err = 0;
   bit vo_at [0:4095];
   bit done_at [0:4095];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_all();
      int exp_err;
`ifdef MAC_ERR_CHECK_EN
      exp_err = int'(m_err);
`else
      exp_err = 0;
`endif
      check("ready",        32'(ready),        (ph != 2) ? 1 : 0);
      check("enable_mode",  32'(enable_mode),  m_en);
      check("result_sel",   32'(result_sel),   m_sel);
      check("valid_out",    32'(valid_out),    int'(vo_at[cyc]));
      check("done",         32'(done),         int'(done_at[cyc]));
      check("sample_count", 32'(sample_count), m_cnt);
      check("err",          32'(err),          exp_err);
   endtask

   task automatic model_reset();
      ph = 0; m_sel = 0; m_cnt = 0; m_en = 0; m_stream = 0; m_err = 0;
      for (int i = 0; i < 4096; i++) begin
         vo_at[i] = 0;
         done_at[i] = 0;
      end
   endtask

   task automatic model_edge(input bit v, input bit l, input int md);
      bit acc;
      int c_max;
      c_max = (1 << CW) - 1;
      acc = v && (ph != 2) && ((ph == 1) || (md < NM));
      if (v && (((ph == 0) && (md >= NM)) || (ph == 2))) m_err = 1;
      if ((ph == 2) && (cyc == end_e)) begin
         ph = 0;
         m_en = 0;
      end
      if (acc) begin
         if (ph == 0) begin
            m_sel = md; m_cnt = 1; m_en = 1 << md; m_stream = (md == 0); m_err = 0;
         end else if (m_cnt < c_max) begin
            m_cnt++;
         end
         if (m_stream || l) vo_at[cyc + PL] = 1;
         if (l) begin
            done_at[cyc + PL] = 1;
            ph = 2;
            end_e = cyc + PL;
         end else begin
            ph = 1;
         end
      end
   endtask

   task automatic step(input bit v, input bit l, input int md);
      valid_in = v;
      last_in  = l;
      mode     = MW'(md);
      @(posedge clk);
      cyc++;
      if (!reset) model_reset();
      else model_edge(v, l, md);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   initial begin
      int low_cnt;
      model_reset();
      idle(2);
      check("rst_ready", 32'(ready), 1);
      check("rst_enable", 32'(enable_mode), 0);
      reset = 1'b1;
      idle(1);

      // streaming job, three back-to-back samples
      step(1, 0, 0);
      check("stream_enable", 32'(enable_mode), 1);
      step(1, 0, 0);
      step(1, 1, 0);
      idle(4);
      check("stream_count", 32'(sample_count), 3);

      // accumulate job with gaps
      for (int i = 1; i <= 5; i++) begin
         step(1, (i == 5), 2);
         if (i < 5) step(0, 0, 0);
      end
      low_cnt = (ready === 1'b0) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0);
         if (ready === 1'b0) low_cnt++;
      end
      check("acc_ready_low", 32'(low_cnt), 2);
      check("acc_sel", 32'(result_sel), 2);

      // single-sample job
      step(1, 1, 1);
      idle(3);
      check("single_count", 32'(sample_count), 1);

      // mode change mid-job, then saturation
      step(1, 0, 1);
      step(1, 0, 3);
      step(1, 1, 3);
      idle(3);
      check("switch_sel", 32'(result_sel), 1);
      for (int i = 1; i <= 10; i++) step(1, (i == 10), 2);
      idle(3);
      check("sat_count", 32'(sample_count), 7);

      // illegal mode, then valid during flush
      step(1, 0, 3);
      check("illegal_enable", 32'(enable_mode), 0);
      idle(1);
      step(1, 1, 0);
      step(1, 0, 0);
      step(1, 1, 1);
      idle(3);

      // asynchronous reset mid-job
      step(1, 0, 1);
      step(1, 0, 1);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all();
      idle(2);
      reset = 1'b1;
      step(1, 0, 2);
      check("restart_count", 32'(sample_count), 1);
      step(1, 1, 2);
      idle(3);

      // random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, ($urandom % 4) == 0, int'($urandom % 4));
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_ctrl_fsm.md
Name: mac_ctrl_fsm

Overview:
Parametrised control FSM for the quadratic-equation MAC datapath.
- Supports NUM_MODES operating modes.
- Latches the mode per job and drives a one-hot datapath enable.
- Tracks accepted samples through a configurable datapath latency.
- Produces valid_out, done, sample_count and an upstream ready/backpressure signal.
- Sits between the input stream source and the MAC datapath/result mux.

Parameters:
NUM_MODES, 4, number of legal modes; mode 0 is streaming, modes 1..NUM_MODES-1 are accumulate.
MODE_W, 2, width of the mode input; NUM_MODES <= 2^MODE_W.
PIPE_LAT, 2, datapath latency in cycles from sample acceptance to result; must be >= 1.
CNT_W, 8, width of sample_count.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
mode  in  MODE_W  requested mode; sampled only when a job starts.
valid_in  in  1  input sample valid.
last_in  in  1  marks the final sample of a job; qualified by valid_in.
ready  out  1  high in IDLE and RUN, low in FLUSH; a sample is accepted when valid_in & ready.
enable_mode  out  NUM_MODES  one-hot datapath enable for the latched mode; all zero in IDLE.
result_sel  out  MODE_W  latched mode of the current/last job, for the result mux.
valid_out  out  1  result-valid strobe.
done  out  1  one-cycle pulse at job completion.
sample_count  out  CNT_W  samples accepted in the current/last job.
err  out  1  sticky error flag; only active with MAC_ERR_CHECK_EN, otherwise tied 0.

Behaviour:
- All outputs are registered. During reset: state IDLE, enable_mode=0, result_sel=0, valid_out=0, done=0, sample_count=0, err=0, latency pipe cleared, ready=1 on release.
- States: IDLE, RUN, FLUSH.
- IDLE, on an accepted valid_in with mode < NUM_MODES:
  - latch mode into result_sel; sample_count <= 1; enable_mode <= 1<<mode.
  - next state is RUN, or FLUSH if last_in=1 (single-sample job).
- IDLE, on valid_in with mode >= NUM_MODES: sample is ignored, state stays IDLE, outputs unchanged.
- RUN:
  - mode input is ignored.
  - each accepted sample increments sample_count, saturating at 2^CNT_W-1.
  - an accepted sample with last_in=1 moves to FLUSH.
  - valid_in=0 cycles simply hold the state.
- FLUSH:
  - ready=0; valid_in is ignored and not counted.
  - a flush counter runs PIPE_LAT cycles after the last accepted sample.
- Latency pipe: a PIPE_LAT-deep shift register of accepted-sample flags. A sample accepted at edge k produces its result strobe high from edge k+PIPE_LAT to edge k+PIPE_LAT+1.
- Mode 0 (streaming): valid_out follows the latency pipe, giving one strobe per accepted sample.
- Modes >= 1 (accumulate): valid_out is a single pulse for the last sample only; intermediate samples give no strobe.
- done: pulses high in the same cycle as the final sample's strobe, in both modes.
- Job completion: at the edge done rises, state returns to IDLE, enable_mode clears and ready rises. A new job may be accepted at the next edge.
- Holding values: result_sel and sample_count hold their values after done until the next job's first accepted sample.
- last_in without valid_in has no effect.
- Reset asserted mid-job aborts immediately; no done is generated.

Optional Feature:
Macro MAC_ERR_CHECK_EN.
- Defined: err is set (sticky) on:
  - valid_in with mode >= NUM_MODES in IDLE, or
  - valid_in=1 during FLUSH (a protocol violation).
  err clears on reset or on acceptance of the next legal job's first sample. Data behaviour is unchanged.
- Undefined: err is constant 0 and no check logic is synthesised.

Test Plan:
1. Streaming: PIPE_LAT=2, mode=0, 3 back-to-back valid samples with last on the 3rd -> valid_out high for 3 consecutive cycles starting 2 cycles after the first acceptance; done coincides with the 3rd strobe; sample_count=3; enable_mode=4'b0001 during the job.
2. Accumulate: mode=2, 5 samples with gaps, last on the 5th -> no intermediate valid_out; one valid_out+done pulse 2 cycles after the 5th acceptance; result_sel=2; enable_mode=4'b0100; ready=0 for exactly 2 cycles.
3. Single-sample job: valid_in=1, last_in=1 in IDLE, mode=1 -> FLUSH directly; valid_out and done 2 cycles later; sample_count=1.
4. Mode switch and saturation: mode changed from 1 to 3 during RUN -> result_sel stays 1. With CNT_W=3, a 10-sample job -> sample_count saturates at 7.
5. Illegal mode and FLUSH violation: mode=3 with NUM_MODES=3, valid_in=1 -> stays IDLE, no enable; with MAC_ERR_CHECK_EN, err=1. valid_in during FLUSH -> ignored; err=1 with the macro, 0 without.
6. Reset mid-job: reset driven 0 in RUN after 2 samples -> all outputs zero immediately, no done. After release, a new job behaves normally and sample_count restarts at 1.
